cp_serializer: RTL and testbench
================================

Name: cp_serializer

Overview:
Downstream neighbour of the 4-point FFT stage. It captures one parallel OFDM symbol of 4 complex samples, prepends a cyclic prefix of CP_LEN samples, and streams the result out one complex sample per beat over a valid/ready interface. A two-slot ping-pong symbol buffer lets the FFT deliver the next symbol while the current one is draining.

Parameters:
W, 5, signed sample width per component; matches the FFT output width.
CP_LEN, 1, cyclic prefix length in samples; legal range 0..3.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  parallel symbol present on i_re*/i_im*.
in_ready  out  1  buffer can accept a symbol; registered, depends only on fill count.
i_re0..i_re3  in  W each  real parts of bins 0..3, signed.
i_im0..i_im3  in  W each  imaginary parts of bins 0..3, signed.
o_valid  out  1  serial sample valid.
o_ready  in  1  downstream accepts the sample.
o_re  out  W  serial real sample, signed.
o_im  out  W  serial imaginary sample, signed.
o_first  out  1  first sample of a symbol, including its prefix.
o_cp  out  1  current sample belongs to the cyclic prefix.
o_last  out  1  final sample (bin 3) of a symbol.

Behaviour:
- Reset (async, any time): fill count = 0, wr_ptr = rd_ptr = 0, FSM = IDLE, idx = 0. While in reset and afterwards until data arrives: o_valid = o_first = o_cp = o_last = 0, o_re = o_im = 0, in_ready = 1. A symbol that is partly sent or buffered is discarded, with no completion beat.
- Storage: 2 slots × 8 words × W bits. Accept happens on in_valid & in_ready: all 8 inputs are written into slot wr_ptr, then wr_ptr toggles and count increments.
- in_ready = (count < 2).
- Output sample order per symbol: bins 4-CP_LEN .. 3 with o_cp = 1, then bins 0..3 with o_cp = 0. Total of 4 + CP_LEN beats.
- FSM states:
  - IDLE: count == 0. o_valid = 0.
  - CP: idx runs 4-CP_LEN..3.
  - DATA: idx runs 0..3.
- Leaving IDLE: when count becomes nonzero, go to CP, or to DATA if CP_LEN == 0. The first sample appears in the cycle right after the accept edge (one-cycle latency).
- Beat transfer: a beat moves on o_valid & o_ready; idx advances only on a transfer.
  - Last CP beat: go to DATA with idx = 0.
  - Beat on bin 3 in DATA (o_last): release slot rd_ptr, toggle rd_ptr, decrement count. Go to CP or DATA if another slot is filled, otherwise IDLE. There are no bubble cycles between back-to-back symbols.
- o_re/o_im are the slot rd_ptr word at idx, all zeros when o_valid = 0. They hold stable while o_valid & !o_ready.
- Flags:
  - o_first = 1 on beat 0 of a symbol only.
  - o_last = 1 on DATA idx 3 only.
  - With CP_LEN = 0, o_first and o_last are never 1 on the same beat, and o_cp is never 1.
- Simultaneous accept and release in one cycle: count stays the same, both pointers toggle. The slot being read is never overwritten, because a slot is released only after its o_last transfer.
- Full buffer (count = 2): in_ready = 0 and in_valid is ignored. in_ready returns 1 in the cycle after the o_last transfer.
- No arithmetic is done: samples pass through bit-exact, with no rounding or saturation.
- o_ready held at 0 indefinitely: state and outputs frozen, no data lost.

Test Plan:
- Single symbol, CP_LEN=1, o_ready=1. Input re = {10,-3,0,15}, im = {-16,1,2,-1}. Required: o_re = 15,10,-3,0,15 and o_im = -1,-16,1,2,-1 on 5 consecutive cycles, starting the cycle after the accept. o_first and o_cp on beat 0 only, o_last on beat 4, then o_valid = 0.
- Backpressure: same symbol, o_ready toggling 1,0,0,1,… Required: each sample is held stable while stalled, the sequence is unchanged, and exactly 5 transfers occur.
- Back-to-back: 3 symbols offered on consecutive cycles with o_ready=1. Required: symbols 1 and 2 are accepted and in_ready falls to 0. Symbol 3 is accepted the cycle after symbol 1's o_last. The output is 15 continuous beats with no gaps, in order.
- Simultaneous accept/release: count = 1 and a new in_valid arrives on the o_last beat. Required: count stays 1, the next symbol starts with no bubble, and the new data is intact.
- Reset mid-symbol: assert rst after beat 2 of a buffered pair. Required: o_valid = 0 immediately (async), in_ready = 1, and no further output until a fresh accept.
- CP_LEN=0 build: the single-symbol stimulus gives o_re = 10,-3,0,15, o_cp always 0, o_first on beat 0, o_last on beat 3.

Source files
------------

// File: rtl/cp_serializer_if.sv
// cp_serializer_if: bus bundle around the cyclic-prefix serializer.
// Carries the parallel symbol handshake from the FFT stage and the serial
// sample handshake towards the downstream consumer.
interface cp_serializer_if #(
  parameter int W = 5
);

  // Parallel symbol side (FFT -> serializer)
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] i_re0;
  logic signed [W-1:0] i_re1;
  logic signed [W-1:0] i_re2;
  logic signed [W-1:0] i_re3;
  logic signed [W-1:0] i_im0;
  logic signed [W-1:0] i_im1;
  logic signed [W-1:0] i_im2;
  logic signed [W-1:0] i_im3;

  // Serial sample side (serializer -> downstream)
  logic                o_valid;
  logic                o_ready;
  logic signed [W-1:0] o_re;
  logic signed [W-1:0] o_im;
  logic                o_first;
  logic                o_cp;
  logic                o_last;

  // Serializer view: consumes symbols, produces samples.
  modport slave (
    input  in_valid,
    output in_ready,
    input  i_re0, i_re1, i_re2, i_re3,
    input  i_im0, i_im1, i_im2, i_im3,
    output o_valid,
    input  o_ready,
    output o_re, o_im,
    output o_first, o_cp, o_last
  );

  // Environment view: offers symbols, accepts samples.
  modport master (
    output in_valid,
    input  in_ready,
    output i_re0, i_re1, i_re2, i_re3,
    output i_im0, i_im1, i_im2, i_im3,
    input  o_valid,
    output o_ready,
    input  o_re, o_im,
    input  o_first, o_cp, o_last
  );

endinterface

// File: rtl/cp_serializer.sv
// cp_serializer: captures one 4-bin complex OFDM symbol, prepends a cyclic
// prefix of CP_LEN samples (the last CP_LEN bins) and streams the result one
// complex sample per beat. Two symbol slots are used ping-pong so the FFT can
// deliver the next symbol while the current one drains.
//
// All outputs are registered. The output registers are loaded from the
// next-state values, so the first sample of a symbol is visible in the cycle
// right after its accept edge, and back-to-back symbols stream without a
// bubble. When the slot being written is the slot that is about to be read
// (empty buffer, or accept coinciding with the release of the only full
// slot), the sample is bypassed straight from the input bus.
module cp_serializer #(
  parameter int W      = 5,
  parameter int CP_LEN = 1
) (
  input  logic           clk,
  input  logic           rst,
  cp_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // First bin index sent for a symbol and the state it is sent in.
  // With CP_LEN = 0 the symbol starts directly at DATA bin 0.
  localparam logic [1:0] START_IDX = 2'(4 - CP_LEN);
  localparam state_t     START_ST  = (CP_LEN == 0) ? ST_DATA : ST_CP;

  // Symbol storage: 2 slots x 4 bins, real and imaginary kept apart.
  logic signed [W-1:0] r_mem_re [2][4];
  logic signed [W-1:0] r_mem_im [2][4];

  // Control state
  state_t     r_state;
  logic [1:0] r_idx;
  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;

  // Registered outputs
  logic                r_in_ready;
  logic                r_o_valid;
  logic                r_o_first;
  logic                r_o_cp;
  logic                r_o_last;
  logic signed [W-1:0] r_o_re;
  logic signed [W-1:0] r_o_im;

  // Combinational next-state values
  state_t              w_state_nxt;
  logic [1:0]          w_idx_nxt;
  logic [1:0]          w_count_nxt;
  logic                w_rd_ptr_nxt;
  logic                w_accept;
  logic                w_xfer;
  logic                w_release;
  logic                w_bypass;
  logic                w_o_valid_nxt;
  logic                w_o_first_nxt;
  logic                w_o_cp_nxt;
  logic                w_o_last_nxt;
  logic signed [W-1:0] w_o_re_nxt;
  logic signed [W-1:0] w_o_im_nxt;

  // Input bins gathered into arrays so they can be indexed by bin number.
  logic signed [W-1:0] w_in_re [4];
  logic signed [W-1:0] w_in_im [4];

  assign w_in_re[0] = bus.i_re0;
  assign w_in_re[1] = bus.i_re1;
  assign w_in_re[2] = bus.i_re2;
  assign w_in_re[3] = bus.i_re3;
  assign w_in_im[0] = bus.i_im0;
  assign w_in_im[1] = bus.i_im1;
  assign w_in_im[2] = bus.i_im2;
  assign w_in_im[3] = bus.i_im3;

  // Handshake events for this cycle. in_ready already encodes count < 2,
  // and o_valid already encodes "a symbol is being sent".
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_xfer    = r_o_valid & bus.o_ready;
  assign w_release = w_xfer & (r_state == ST_DATA) & (r_idx == 2'd3);

  // Read pointer moves to the other slot once the current symbol is fully sent.
  assign w_rd_ptr_nxt = r_rd_ptr ^ w_release;

  // The slot written this cycle is the one read next: take samples from the bus.
  assign w_bypass = w_accept & (r_wr_ptr == w_rd_ptr_nxt);

  // Fill count: accept and release in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_release})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FSM next state and sample index; idx only moves on a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = START_ST;
          w_idx_nxt   = START_IDX;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 2'd0;
        end
      end
      ST_CP: begin
        if (w_xfer) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = 2'd0;
          end else begin
            w_state_nxt = ST_CP;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end else begin
          w_state_nxt = r_state;
          w_idx_nxt   = r_idx;
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          if (r_idx == 2'd3) begin
            // Symbol complete: chain straight into the next one if buffered.
            if (w_count_nxt != 2'd0) begin
              w_state_nxt = START_ST;
              w_idx_nxt   = START_IDX;
            end else begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 2'd0;
            end
          end else begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end else begin
          w_state_nxt = r_state;
          w_idx_nxt   = r_idx;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // Next output values, derived from where the FSM will be next cycle.
  always_comb begin
    w_o_valid_nxt = (w_state_nxt != ST_IDLE);
    w_o_first_nxt = w_o_valid_nxt & (w_state_nxt == START_ST) & (w_idx_nxt == START_IDX);
    w_o_cp_nxt    = (w_state_nxt == ST_CP);
    w_o_last_nxt  = (w_state_nxt == ST_DATA) & (w_idx_nxt == 2'd3);
    w_o_re_nxt    = '0;
    w_o_im_nxt    = '0;
    if (!w_o_valid_nxt) begin
      w_o_re_nxt = '0;
      w_o_im_nxt = '0;
    end else if (w_bypass) begin
      w_o_re_nxt = w_in_re[w_idx_nxt];
      w_o_im_nxt = w_in_im[w_idx_nxt];
    end else begin
      w_o_re_nxt = r_mem_re[w_rd_ptr_nxt][w_idx_nxt];
      w_o_im_nxt = r_mem_im[w_rd_ptr_nxt][w_idx_nxt];
    end
  end

  // FSM state, index, fill count and slot pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_count  <= w_count_nxt;
      r_wr_ptr <= r_wr_ptr ^ w_accept;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Symbol slot write: all eight words of an accepted symbol land in slot wr_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < 4; b++) begin
          r_mem_re[s][b] <= '0;
          r_mem_im[s][b] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int b = 0; b < 4; b++) begin
        r_mem_re[r_wr_ptr][b] <= w_in_re[b];
        r_mem_im[r_wr_ptr][b] <= w_in_im[b];
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < 4; b++) begin
          r_mem_re[s][b] <= r_mem_re[s][b];
          r_mem_im[s][b] <= r_mem_im[s][b];
        end
      end
    end
  end

  // Output registers; in_ready follows the next fill count only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b1;
      r_o_valid  <= 1'b0;
      r_o_first  <= 1'b0;
      r_o_cp     <= 1'b0;
      r_o_last   <= 1'b0;
      r_o_re     <= '0;
      r_o_im     <= '0;
    end else begin
      r_in_ready <= (w_count_nxt < 2'd2);
      r_o_valid  <= w_o_valid_nxt;
      r_o_first  <= w_o_first_nxt;
      r_o_cp     <= w_o_cp_nxt;
      r_o_last   <= w_o_last_nxt;
      r_o_re     <= w_o_re_nxt;
      r_o_im     <= w_o_im_nxt;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.o_valid  = r_o_valid;
  assign bus.o_first  = r_o_first;
  assign bus.o_cp     = r_o_cp;
  assign bus.o_last   = r_o_last;
  assign bus.o_re     = r_o_re;
  assign bus.o_im     = r_o_im;

endmodule

// File: tb/tb_cp_serializer.sv
// tb_cp_serializer: drives a CP_LEN=1 and a CP_LEN=0 serializer with the same
// directed stimulus. A symbol-level model (2-entry FIFO of symbols plus a beat
// position) predicts every output each cycle; directed literals pin the model.
module tb_cp_serializer;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp_serializer_if #(.W(W)) bus0 ();
  cp_serializer_if #(.W(W)) bus1 ();

  cp_serializer #(.W(W), .CP_LEN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  cp_serializer #(.W(W), .CP_LEN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Shared stimulus
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_re [4];
  logic signed [W-1:0] s_im [4];

  assign bus0.in_valid = s_valid;
  assign bus1.in_valid = s_valid;
  assign bus0.o_ready  = s_ready;
  assign bus1.o_ready  = s_ready;
  assign bus0.i_re0 = s_re[0]; assign bus0.i_re1 = s_re[1];
  assign bus0.i_re2 = s_re[2]; assign bus0.i_re3 = s_re[3];
  assign bus0.i_im0 = s_im[0]; assign bus0.i_im1 = s_im[1];
  assign bus0.i_im2 = s_im[2]; assign bus0.i_im3 = s_im[3];
  assign bus1.i_re0 = s_re[0]; assign bus1.i_re1 = s_re[1];
  assign bus1.i_re2 = s_re[2]; assign bus1.i_re3 = s_re[3];
  assign bus1.i_im0 = s_im[0]; assign bus1.i_im1 = s_im[1];
  assign bus1.i_im2 = s_im[2]; assign bus1.i_im3 = s_im[3];

  // Packed view of each DUT: {in_ready, valid, first, cp, last, re, im}
  logic [14:0] d_out [2];
  assign d_out[0] = {bus0.in_ready, bus0.o_valid, bus0.o_first, bus0.o_cp, bus0.o_last, bus0.o_re, bus0.o_im};
  assign d_out[1] = {bus1.in_ready, bus1.o_valid, bus1.o_first, bus1.o_cp, bus1.o_last, bus1.o_re, bus1.o_im};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_re  [2][2][4];
  int  m_im  [2][2][4];
  int  m_cnt [2];
  int  m_pos [2];
  int  mc_cp, mc_bin;
  logic [14:0] mc_exp;
  logic        e_rdy, e_val, e_fst, e_cp, e_lst;
  logic [4:0]  e_re, e_im;

  // Compare at the falling edge, then predict the coming rising edge using
  // the inputs the stimulus holds stable over this half cycle.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_pos[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 0;
          m_pos[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          mc_cp = (k == 0) ? 1 : 0;
          e_rdy = (m_cnt[k] < 2);
          e_val = (m_cnt[k] > 0);
          e_fst = 1'b0; e_cp = 1'b0; e_lst = 1'b0; e_re = 5'd0; e_im = 5'd0;
          if (e_val) begin
            mc_bin = (m_pos[k] < mc_cp) ? (4 - mc_cp + m_pos[k]) : (m_pos[k] - mc_cp);
            e_fst  = (m_pos[k] == 0);
            e_cp   = (m_pos[k] < mc_cp);
            e_lst  = (m_pos[k] == mc_cp + 3);
            e_re   = 5'(m_re[k][0][mc_bin]);
            e_im   = 5'(m_im[k][0][mc_bin]);
          end
          mc_exp = {e_rdy, e_val, e_fst, e_cp, e_lst, e_re, e_im};
          n_tests++;
          if (d_out[k] !== mc_exp) begin
            n_fail++;
            $display("FAIL model_dut%0d t=%0t: got %h, expected %h", k, $time, d_out[k], mc_exp);
          end
          // advance to the state after the next rising edge
          if (e_val && s_ready) begin
            m_pos[k]++;
            if (m_pos[k] == 4 + mc_cp) begin
              m_pos[k] = 0;
              for (int b = 0; b < 4; b++) begin
                m_re[k][0][b] = m_re[k][1][b];
                m_im[k][0][b] = m_im[k][1][b];
              end
              m_cnt[k]--;
            end
          end
          if (s_valid && e_rdy) begin
            for (int b = 0; b < 4; b++) begin
              m_re[k][m_cnt[k]][b] = int'(s_re[b]);
              m_im[k][m_cnt[k]][b] = int'(s_im[b]);
            end
            m_cnt[k]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0, vrun = 0, first_v = -1, last_v = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus0.o_valid) begin
      vrun++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic drive(input int r0, input int r1, input int r2, input int r3,
                       input int i0, input int i1, input int i2, input int i3);
    s_re[0] = 5'(r0); s_re[1] = 5'(r1); s_re[2] = 5'(r2); s_re[3] = 5'(r3);
    s_im[0] = 5'(i0); s_im[1] = 5'(i1); s_im[2] = 5'(i2); s_im[3] = 5'(i3);
    s_valid = 1'b1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t1_re0 [5] = '{15, 10, -3, 0, 15};
  int t1_im0 [5] = '{-1, -16, 1, 2, -1};
  int t1_re1 [4] = '{10, -3, 0, 15};
  int t1_im1 [4] = '{-16, 1, 2, -1};
  int x0, x1, nw;

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_re[b] = '0;
      s_im[b] = '0;
    end
    #1;
    check("rst_valid0", int'(bus0.o_valid), 0);
    check("rst_valid1", int'(bus1.o_valid), 0);
    check("rst_ready0", int'(bus0.in_ready), 1);
    check("rst_re0", int'(bus0.o_re), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(); tick();

    // T1: single symbol, o_ready = 1
    drive(10, -3, 0, 15, -16, 1, 2, -1);
    tick();
    s_valid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check($sformatf("t1_valid0_b%0d", b), int'(bus0.o_valid), 1);
      check($sformatf("t1_re0_b%0d", b), int'(bus0.o_re), t1_re0[b]);
      check($sformatf("t1_im0_b%0d", b), int'(bus0.o_im), t1_im0[b]);
      check($sformatf("t1_first0_b%0d", b), int'(bus0.o_first), int'(b == 0));
      check($sformatf("t1_cp0_b%0d", b), int'(bus0.o_cp), int'(b == 0));
      check($sformatf("t1_last0_b%0d", b), int'(bus0.o_last), int'(b == 4));
      if (b < 4) begin
        check($sformatf("cp0_re_b%0d", b), int'(bus1.o_re), t1_re1[b]);
        check($sformatf("cp0_im_b%0d", b), int'(bus1.o_im), t1_im1[b]);
        check($sformatf("cp0_cp_b%0d", b), int'(bus1.o_cp), 0);
        check($sformatf("cp0_first_b%0d", b), int'(bus1.o_first), int'(b == 0));
        check($sformatf("cp0_last_b%0d", b), int'(bus1.o_last), int'(b == 3));
      end else begin
        check("cp0_done_valid", int'(bus1.o_valid), 0);
      end
      tick();
    end
    check("t1_done_valid0", int'(bus0.o_valid), 0);
    tick();

    // T2: backpressure, including a long stall before any transfer
    s_ready = 1'b0;
    drive(10, -3, 0, 15, -16, 1, 2, -1);
    tick();
    s_valid = 1'b0;
    repeat (8) tick();
    x0 = 0; x1 = 0;
    for (int i = 0; i < 40; i++) begin
      s_ready = (i % 3 == 0);
      if (bus0.o_valid && s_ready) x0++;
      if (bus1.o_valid && s_ready) x1++;
      tick();
    end
    s_ready = 1'b1;
    check("bp_xfers0", x0, 5);
    check("bp_xfers1", x1, 4);
    tick();

    // T3: three symbols back to back
    vrun = 0; first_v = -1; last_v = -1;
    drive(1, -2, 3, -4, 5, -6, 7, -8);
    tick();
    drive(-16, 15, -1, 0, 8, -9, 11, -13);
    tick();
    check("b2b_ready_low", int'(bus0.in_ready), 0);
    drive(9, 10, -11, 12, -14, 13, -15, 14);
    nw = 0;
    while (nw < 20 && !bus0.in_ready) begin
      tick();
      nw++;
    end
    check("b2b_ready_wait", nw, 4);
    tick();
    s_valid = 1'b0;
    repeat (25) tick();
    check("b2b_beats", vrun, 15);
    check("b2b_span", last_v - first_v + 1, 15);

    // T4: accept on the o_last beat with count = 1
    drive(7, -7, 6, -6, -5, 5, -4, 4);
    tick();
    s_valid = 1'b0;
    repeat (4) tick();
    check("sim_last_beat", int'(bus0.o_last), 1);
    drive(3, -3, 2, -2, 1, -1, -16, 15);
    tick();
    s_valid = 1'b0;
    check("sim_valid", int'(bus0.o_valid), 1);
    check("sim_first", int'(bus0.o_first), 1);
    check("sim_re", int'(bus0.o_re), -2);
    check("sim_im", int'(bus0.o_im), 15);
    check("sim_ready", int'(bus0.in_ready), 1);
    repeat (12) tick();

    // T5: asynchronous reset in the middle of a buffered pair
    drive(4, 3, 2, 1, -1, -2, -3, -4);
    tick();
    drive(-8, 8, -7, 7, 6, -6, 5, -5);
    tick();
    s_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid0", int'(bus0.o_valid), 0);
    check("arst_valid1", int'(bus1.o_valid), 0);
    check("arst_ready0", int'(bus0.in_ready), 1);
    check("arst_ready1", int'(bus1.in_ready), 1);
    check("arst_re0", int'(bus0.o_re), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("arst_quiet_%0d", i), int'(bus0.o_valid), 0);
    end
    drive(1, -2, 3, -4, 5, -6, 7, -8);
    tick();
    s_valid = 1'b0;
    check("arst_fresh_re", int'(bus0.o_re), -4);
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
